dump_sequencer: RTL and testbench
=================================

# dump_sequencer

Parametrised trace-dump sequencer for the scope's capture path. It replaces the fixed three-channel dump state machine. On a dump command it does three things:
- fetches the selected channel's gain/offset calibration words from the EEPROM over SPI;
- walks the full trace RAM ring from the oldest sample, handing each sample to the UART response path;
- signals completion.

It sits between the command decoder, the SPI master, the trace RAM read port and the UART transmitter. It adds abort, bad-channel rejection and an internal read-address counter.

## Interface
- NUM_CH, 3: number of analog channels; CH_W = $clog2(NUM_CH), minimum 1.
- ADDR_W, 9: trace RAM address width; a dump sends 2^ADDR_W samples.
- GAIN_W, 3: per-channel AFE gain code width; CH_W+GAIN_W ≤ 6.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_dump  in  1  one-cycle dump command
- abort  in  1  cancel the dump in progress
- channel  in  CH_W  channel index of the command
- ch_gain  in  NUM_CH*GAIN_W  packed gain codes; channel i uses bits [i*GAIN_W +: GAIN_W]
- trace_ptr  in  ADDR_W  oldest-sample address, captured at start
- spi_rdy  in  1  SPI master idle/transaction complete (level)
- uart_rdy  in  1  UART transmitter idle (level)
- spi_start  out  1  launch an SPI transaction
- spi_tx  out  16  SPI command word
- flop_gain, flop_offset  out  1  load the calibration register from SPI receive data
- uart_start  out  1  send the current sample
- rd_addr  out  ADDR_W  trace RAM read address
- ch_sel  out  CH_W  captured channel
- busy  out  1  state ≠ IDLE
- dump_done, aborted, bad_ch  out  1  one-cycle status pulses

## Operation
- Calibration index: idx[5:0] = zero-extended {ch_sel, gain of ch_sel}.
- Gain read command: spi_tx = {2'b00, idx, 7'b0, 1'b1}.
- Offset read and junk (flush) commands: spi_tx = {2'b00, idx, 8'h00}.
- spi_tx is 0 whenever spi_start is low.
- Counter cnt is ADDR_W+1 bits wide and counts samples sent.
- rd_addr increments mod 2^ADDR_W.
- State machine:
  - IDLE: on start_dump with channel < NUM_CH: capture ch_sel←channel, rd_addr←trace_ptr, cnt←0, go to CAL_GAIN. On start_dump with channel ≥ NUM_CH: pulse bad_ch and stay in IDLE.
  - CAL_GAIN: spi_start with the gain command → CAL_OFF.
  - CAL_OFF: wait for spi_rdy; when it is seen, spi_start with the offset command → CAL_JUNK.
  - CAL_JUNK: wait for spi_rdy; when it is seen, flop_gain=1 and spi_start with the junk command → CAL_WAIT.
  - CAL_WAIT: wait for spi_rdy; when it is seen, flop_offset=1 → NEXT.
  - NEXT: RAM read-latency cycle. If cnt == 2^ADDR_W → DRAIN, else → SEND.
  - SEND: wait for uart_rdy; when it is seen, uart_start=1, rd_addr+1, cnt+1 → NEXT.
  - DRAIN: wait for uart_rdy; when it is seen, pulse dump_done → IDLE.
- abort in any non-IDLE state:
  - forces IDLE on the next edge, pulses aborted, and suppresses every other output that cycle;
  - has priority over all transitions;
  - is ignored in IDLE.
- start_dump outside IDLE is ignored.
- spi_rdy and uart_rdy are ignored in IDLE, so in-flight transactions after an abort are harmless.
- ch_sel and rd_addr hold their values after the dump ends.

## Timing
- Reset: state IDLE; ch_sel=0, rd_addr=0, cnt=0; every output low, spi_tx=0.
- Strobes (spi_start, flop_*, uart_start, dump_done, aborted, bad_ch) are combinational decodes of state and inputs (Mealy). Each is high for exactly one cycle.
- Handshake contract: the SPI master and UART drop spi_rdy/uart_rdy on the cycle after they sample their start strobe.
- start_dump at cycle 0 → CAL_GAIN spi_start at cycle 1.
- The NEXT state guarantees at least one cycle between an rd_addr change and the following uart_start.
- Minimum per-sample period: 2 cycles.
- Reset mid-dump: IDLE immediately; no dump_done or aborted pulse.

## Configuration
- DSM_CAL_EN defined: full calibration sequence as described above.
- DSM_CAL_EN undefined:
  - CAL_* states are removed and IDLE goes directly to NEXT;
  - spi_start, spi_tx, flop_gain and flop_offset are tied to 0;
  - spi_rdy is unused.

## Test plan
- Reset asserted mid-SEND → all outputs 0, rd_addr=0, busy=0 on the same cycle; release, then a new dump completes normally.
- Full dump, NUM_CH=3, ADDR_W=4, ch_gain[5:3]=3'b101, channel=1, trace_ptr=4'hC, DSM_CAL_EN defined, responders always ready:
  - spi_tx sequence 16'h0D01, 16'h0D00, 16'h0D00;
  - flop_gain, then flop_offset, each pulsed once;
  - 16 uart_start pulses with rd_addr C,D,E,F,0…B;
  - dump_done once, final rd_addr=C.
- channel=3 with NUM_CH=3 → bad_ch for one cycle, busy stays 0, no spi_start.
- abort one cycle after the 5th uart_start → IDLE next cycle, aborted pulse, no dump_done; a following start_dump with channel=0 runs to dump_done.
- Backpressure: uart_rdy held low 20 cycles in SEND and spi_rdy held low 10 cycles in CAL_OFF → no strobes while low; the sequence resumes on the cycle the ready signal rises.
- DSM_CAL_EN undefined, ADDR_W=4, start_dump at cycle 0 → no spi_start ever, first uart_start at cycle 2, dump_done after 16 samples.

Source files
------------

// File: rtl/dump_sequencer.sv
// Trace-dump sequencer: optional SPI calibration fetch, then streams the whole trace RAM ring to the UART.
// Build option DSM_CAL_EN enables the EEPROM gain/offset calibration states; without it a dump starts streaming at once.
module dump_sequencer #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 9,
    parameter int GAIN_W = 3,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_dump,
    input  logic                     abort,
    input  logic [CH_W-1:0]          channel,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [ADDR_W-1:0]        trace_ptr,
    input  logic                     spi_rdy,
    input  logic                     uart_rdy,
    output logic                     spi_start,
    output logic [15:0]              spi_tx,
    output logic                     flop_gain,
    output logic                     flop_offset,
    output logic                     uart_start,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [CH_W-1:0]          ch_sel,
    output logic                     busy,
    output logic                     dump_done,
    output logic                     aborted,
    output logic                     bad_ch,
    output logic [2:0]               dbg_state
);

    // Handshake: a strobe (spi_start/uart_start) fires in the cycle the matching
    // ready level is seen high; the responder drops ready the cycle after.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
`ifdef DSM_CAL_EN
        CAL_GAIN = 3'd1,
        CAL_OFF  = 3'd2,
        CAL_JUNK = 3'd3,
        CAL_WAIT = 3'd4,
`endif
        NEXT     = 3'd5,
        SEND     = 3'd6,
        DRAIN    = 3'd7
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ch_ok;

    assign ch_ok = (32'(channel) < 32'(NUM_CH));

`ifdef DSM_CAL_EN
    logic [GAIN_W-1:0] gain_sel;
    logic [5:0]        idx;
    logic [15:0]       gain_cmd;
    logic [15:0]       off_cmd;

    assign gain_sel = ch_gain[ch_sel_q*GAIN_W +: GAIN_W];

    always_comb begin
        idx = '0;
        idx[CH_W+GAIN_W-1:0] = {ch_sel_q, gain_sel};
    end

    assign gain_cmd = {2'b00, idx, 7'b0, 1'b1};
    assign off_cmd  = {2'b00, idx, 8'h00};
`else
    logic unused_cal;
    assign unused_cal  = ^{spi_rdy, ch_gain};
    assign spi_start   = 1'b0;
    assign spi_tx      = 16'h0000;
    assign flop_gain   = 1'b0;
    assign flop_offset = 1'b0;
`endif

    // Next state and Mealy strobes; abort outranks everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        rd_addr_d  = rd_addr_q;
        cnt_d      = cnt_q;
        uart_start = 1'b0;
        dump_done  = 1'b0;
        aborted    = 1'b0;
        bad_ch     = 1'b0;
`ifdef DSM_CAL_EN
        spi_start   = 1'b0;
        spi_tx      = 16'h0000;
        flop_gain   = 1'b0;
        flop_offset = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (start_dump) begin
                if (ch_ok) begin
                    ch_sel_d  = channel;
                    rd_addr_d = trace_ptr;
                    cnt_d     = '0;
`ifdef DSM_CAL_EN
                    state_d   = CAL_GAIN;
`else
                    state_d   = NEXT;
`endif
                end else begin
                    bad_ch = 1'b1;
                end
            end
        end else if (abort) begin
            aborted = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
`ifdef DSM_CAL_EN
                CAL_GAIN: begin
                    spi_start = 1'b1;
                    spi_tx    = gain_cmd;
                    state_d   = CAL_OFF;
                end
                CAL_OFF: begin
                    if (spi_rdy) begin
                        spi_start = 1'b1;
                        spi_tx    = off_cmd;
                        state_d   = CAL_JUNK;
                    end
                end
                CAL_JUNK: begin
                    // Gain word arrives while the offset read is clocked; a junk read flushes the offset.
                    if (spi_rdy) begin
                        flop_gain = 1'b1;
                        spi_start = 1'b1;
                        spi_tx    = off_cmd;
                        state_d   = CAL_WAIT;
                    end
                end
                CAL_WAIT: begin
                    if (spi_rdy) begin
                        flop_offset = 1'b1;
                        state_d     = NEXT;
                    end
                end
`endif
                NEXT: begin
                    state_d = (cnt_q == FULL_CNT) ? DRAIN : SEND;
                end
                SEND: begin
                    if (uart_rdy) begin
                        uart_start = 1'b1;
                        rd_addr_d  = rd_addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q + (ADDR_W+1)'(1);
                        state_d    = NEXT;
                    end
                end
                DRAIN: begin
                    if (uart_rdy) begin
                        dump_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_sel_q  <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign ch_sel    = ch_sel_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Bench for dump_sequencer (NUM_CH=3, ADDR_W=4, GAIN_W=3); follows DSM_CAL_EN like the design.
module tb_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_dump, abort;
    logic [1:0]  channel;
    logic [8:0]  ch_gain;
    logic [3:0]  trace_ptr;
    logic        spi_rdy, uart_rdy;
    logic        spi_start, flop_gain, flop_offset, uart_start;
    logic [15:0] spi_tx;
    logic [3:0]  rd_addr;
    logic [1:0]  ch_sel;
    logic        busy, dump_done, aborted, bad_ch;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    dump_sequencer #(.NUM_CH(3), .ADDR_W(4), .GAIN_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .abort(abort),
        .channel(channel), .ch_gain(ch_gain), .trace_ptr(trace_ptr),
        .spi_rdy(spi_rdy), .uart_rdy(uart_rdy), .spi_start(spi_start),
        .spi_tx(spi_tx), .flop_gain(flop_gain), .flop_offset(flop_offset),
        .uart_start(uart_start), .rd_addr(rd_addr), .ch_sel(ch_sel),
        .busy(busy), .dump_done(dump_done), .aborted(aborted), .bad_ch(bad_ch),
        .dbg_state(dbg_state)
    );

    localparam logic [6:0] S_SPI = 7'b1000000;
    localparam logic [6:0] S_FG  = 7'b0100000;
    localparam logic [6:0] S_FO  = 7'b0010000;
    localparam logic [6:0] S_US  = 7'b0001000;
    localparam logic [6:0] S_DD  = 7'b0000100;
    localparam logic [6:0] S_AB  = 7'b0000010;
    localparam logic [6:0] S_BC  = 7'b0000001;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_strobe = 0;
    int n_uart   = 0;

    logic [6:0] strobes;
    assign strobes = {spi_start, flop_gain, flop_offset, uart_start, dump_done, aborted, bad_ch};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic logic [31:0] ev(input logic [6:0] s, input logic [15:0] tx, input logic [3:0] a);
        return {5'b0, s, tx, a};
    endfunction

    // Monitor: every cycle with any strobe is one observed event, matched in order.
    always @(negedge clk) begin
        if (strobes != 7'b0) begin
            n_strobe++;
            if (uart_start) n_uart++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got %h required none (t=%0t)",
                         {5'b0, strobes, spi_tx, rd_addr}, $time);
            end else begin
                check("strobe_seq", {5'b0, strobes, spi_tx, rd_addr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cal(input logic [15:0] gtx, input logic [15:0] otx, input logic [3:0] a);
`ifdef DSM_CAL_EN
        exp_q.push_back(ev(S_SPI, gtx, a));
        exp_q.push_back(ev(S_SPI, otx, a));
        exp_q.push_back(ev(S_SPI | S_FG, otx, a));
        exp_q.push_back(ev(S_FO, 16'h0, a));
`else
        if (gtx == otx) $display("note: identical cal words %h", gtx);
`endif
    endtask

    task automatic push_samples(input logic [3:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] a;
            a = base + 4'(i);
            exp_q.push_back(ev(S_US, 16'h0, a));
        end
    endtask

    task automatic push_dump(input logic [15:0] gtx, input logic [15:0] otx, input logic [3:0] ptr);
        push_cal(gtx, otx, ptr);
        push_samples(ptr, 16);
        exp_q.push_back(ev(S_DD, 16'h0, ptr));
    endtask

    task automatic do_start(input logic [1:0] ch, input logic [3:0] ptr);
        channel    = ch;
        trace_ptr  = ptr;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            tick();
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    int snap;
    int base;

    initial begin
        rst_n = 1'b0; start_dump = 1'b0; abort = 1'b0; channel = 2'd0;
        ch_gain = {3'b000, 3'b101, 3'b011};
        trace_ptr = 4'h0; spi_rdy = 1'b1; uart_rdy = 1'b1;
        repeat (2) tick();
        check("rst_strobes", {25'b0, strobes}, 32'd0);
        check("rst_spi_tx", {16'b0, spi_tx}, 32'd0);
        check("rst_rd_addr", {28'b0, rd_addr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ch_sel", {30'b0, ch_sel}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full dump, channel 1 (gain 101), oldest sample at C.
        push_dump(16'h0D01, 16'h0D00, 4'hC);
        do_start(2'd1, 4'hC);
`ifdef DSM_CAL_EN
        check("cal_first_cycle", {15'b0, spi_start, spi_tx}, {15'b0, 1'b1, 16'h0D01});
`else
        tick();
        check("first_uart_cycle2", {31'b0, uart_start}, 32'd1);
`endif
        wait_idle("dump1_idle");
        check("dump1_final_addr", {28'b0, rd_addr}, 32'hC);
        check("dump1_ch_sel", {30'b0, ch_sel}, 32'd1);

        // Out-of-range channel.
        exp_q.push_back(ev(S_BC, 16'h0, 4'hC));
        do_start(2'd3, 4'h7);
        check("bad_busy", {31'b0, busy}, 32'd0);
        check("bad_addr_hold", {28'b0, rd_addr}, 32'hC);
        tick();

        // Abort one cycle after the 5th sample.
        push_cal(16'h0301, 16'h0300, 4'h3);
        push_samples(4'h3, 5);
        exp_q.push_back(ev(S_AB, 16'h0, 4'h8));
        base = n_uart;
        do_start(2'd0, 4'h3);
        for (int i = 0; i < 300; i++) begin
            if (n_uart >= base + 5) break;
            tick();
        end
        check("abort_reached", n_uart - base, 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        tick();
        push_dump(16'h0301, 16'h0300, 4'h3);
        do_start(2'd0, 4'h3);
        wait_idle("rerun_idle");
        check("rerun_final_addr", {28'b0, rd_addr}, 32'h3);

        // Backpressure on both responders, channel 2 (gain 000).
        spi_rdy = 1'b0;
        uart_rdy = 1'b0;
        push_dump(16'h1001, 16'h1000, 4'h0);
        do_start(2'd2, 4'h0);
`ifdef DSM_CAL_EN
        tick();
        snap = n_strobe;
        repeat (10) tick();
        check("spi_quiet", n_strobe - snap, 32'd0);
        spi_rdy = 1'b1;
        #1;
        check("spi_resume", {15'b0, spi_start, spi_tx}, {15'b0, 1'b1, 16'h1000});
        repeat (4) tick();
`else
        tick();
`endif
        snap = n_strobe;
        repeat (20) tick();
        check("uart_quiet", n_strobe - snap, 32'd0);
        uart_rdy = 1'b1;
        #1;
        check("uart_resume", {27'b0, uart_start, rd_addr}, {27'b0, 1'b1, 4'h0});
        wait_idle("bp_idle");
        check("bp_final_addr", {28'b0, rd_addr}, 32'h0);
        spi_rdy = 1'b1;

        // Reset while stalled in SEND.
        uart_rdy = 1'b0;
        push_cal(16'h0D01, 16'h0D00, 4'h5);
        do_start(2'd1, 4'h5);
`ifdef DSM_CAL_EN
        repeat (5) tick();
`else
        tick();
`endif
        rst_n = 1'b0;
        uart_rdy = 1'b1;
        #1;
        check("rstmid_strobes", {25'b0, strobes}, 32'd0);
        check("rstmid_rd_addr", {28'b0, rd_addr}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_spi_tx", {16'b0, spi_tx}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_dump(16'h0301, 16'h0300, 4'hA);
        do_start(2'd0, 4'hA);
        wait_idle("post_rst_idle");
        check("post_rst_addr", {28'b0, rd_addr}, 32'hA);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
